// File: rtl/exe_muldiv_stage_if.sv
// rtl/exe_muldiv_stage_if.sv - ID/EXE/MEM handshake and operand bundle for the mul/div execute slot
interface exe_muldiv_stage_if #(
  parameter int DATA_W = 32
);
  logic              id_valid_in;
  logic              exe_allowin_out;
  logic              exe_valid_out;
  logic              mem_allowin_in;
  logic              flush_in;
  logic [3:0]        id_op_in;
  logic [DATA_W-1:0] id_src0_in;
  logic [DATA_W-1:0] id_src1_in;
  logic [DATA_W-1:0] exe_result_out;
  logic              exe_busy_out;
  logic [DATA_W-1:0] exe_hi_out;
  logic [DATA_W-1:0] exe_lo_out;

  modport master (
    output id_valid_in, mem_allowin_in, flush_in, id_op_in, id_src0_in, id_src1_in,
    input  exe_allowin_out, exe_valid_out, exe_result_out, exe_busy_out, exe_hi_out, exe_lo_out
  );

  modport slave (
    input  id_valid_in, mem_allowin_in, flush_in, id_op_in, id_src0_in, id_src1_in,
    output exe_allowin_out, exe_valid_out, exe_result_out, exe_busy_out, exe_hi_out, exe_lo_out
  );
endinterface

// File: rtl/exe_muldiv_stage.sv
// rtl/exe_muldiv_stage.sv - execute slot with multi-cycle multiply, restoring divider and HI/LO
module exe_muldiv_stage #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_EN     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  exe_muldiv_stage_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [3:0] OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3, OP_DIVU = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7, OP_MTLO = 4'd8;

  logic              valid_r, busy, fresh;
  logic [CW-1:0]     cnt, cnt_load;
  logic [3:0]        op_r;
  logic [DATA_W-1:0] a_r, b_r, hi, lo, hi_nxt, lo_nxt;
  logic [DATA_W-1:0] rem, quo, dvs, dvd_mag, dvs_mag;
  logic [DATA_W-1:0] step_rem, step_quo, q_fix, r_fix;
  logic [DATA_W:0]   shifted, trial;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic              ready, allowin, capture, commit, is_div_r;

  assign ready   = !busy;
  assign allowin = !valid_r || (ready && bus.mem_allowin_in);
  assign capture = bus.id_valid_in && allowin && !bus.flush_in;
  // fresh covers single-cycle ops; busy with cnt==1 is the edge where busy falls
  assign commit  = valid_r && !bus.flush_in && ((busy && cnt == CW'(1)) || (fresh && !busy));
  assign is_div_r = (op_r == OP_DIV) || (op_r == OP_DIVU);

  always_comb begin
    cnt_load = '0;
    if (bus.id_op_in == OP_MULT || bus.id_op_in == OP_MULTU)
      cnt_load = CW'(MUL_CYCLES - 1);
    else if ((bus.id_op_in == OP_DIV || bus.id_op_in == OP_DIVU) && DIV_EN != 0)
      cnt_load = CW'(DATA_W);
  end

  assign dvd_mag = (bus.id_op_in == OP_DIV && bus.id_src0_in[DATA_W-1]) ? -bus.id_src0_in : bus.id_src0_in;
  assign dvs_mag = (bus.id_op_in == OP_DIV && bus.id_src1_in[DATA_W-1]) ? -bus.id_src1_in : bus.id_src1_in;

  // one restoring step: the borrow bit of trial decides the quotient bit
  assign shifted  = {rem, quo[DATA_W-1]};
  assign trial    = shifted - {1'b0, dvs};
  assign step_rem = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign step_quo = {quo[DATA_W-2:0], !trial[DATA_W]};
  assign q_fix = (op_r == OP_DIV && (a_r[DATA_W-1] ^ b_r[DATA_W-1])) ? -step_quo : step_quo;
  assign r_fix = (op_r == OP_DIV && a_r[DATA_W-1]) ? -step_rem : step_rem;

  assign prod_u = {{DATA_W{1'b0}}, a_r} * {{DATA_W{1'b0}}, b_r};
  assign prod_s = {{DATA_W{a_r[DATA_W-1]}}, a_r} * {{DATA_W{b_r[DATA_W-1]}}, b_r};

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    if (commit) begin
      case (op_r)
        OP_MULT:  {hi_nxt, lo_nxt} = prod_s;
        OP_MULTU: {hi_nxt, lo_nxt} = prod_u;
        OP_DIV, OP_DIVU: begin
          if (DIV_EN == 0) begin
            hi_nxt = '0;
            lo_nxt = '0;
          end else if (b_r == '0) begin
            hi_nxt = a_r;
            lo_nxt = '1;
          end else begin
            hi_nxt = r_fix;
            lo_nxt = q_fix;
          end
        end
        OP_MTHI: hi_nxt = a_r;
        OP_MTLO: lo_nxt = a_r;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      busy    <= 1'b0;
      fresh   <= 1'b0;
      cnt     <= '0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      hi      <= '0;
      lo      <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else begin
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      fresh <= capture;
      if (bus.flush_in) begin
        valid_r <= 1'b0;
        busy    <= 1'b0;
        cnt     <= '0;
      end else if (capture) begin
        valid_r <= 1'b1;
        op_r    <= bus.id_op_in;
        a_r     <= bus.id_src0_in;
        b_r     <= bus.id_src1_in;
        cnt     <= cnt_load;
        busy    <= (cnt_load != '0);
        rem     <= '0;
        quo     <= dvd_mag;
        dvs     <= dvs_mag;
      end else begin
        if (valid_r && ready && bus.mem_allowin_in)
          valid_r <= 1'b0;
        if (busy) begin
          cnt  <= cnt - CW'(1);
          busy <= (cnt != CW'(1));
          if (is_div_r) begin
            rem <= step_rem;
            quo <= step_quo;
          end
        end
      end
    end
  end

  always_comb begin
    case (op_r)
      OP_MFHI: bus.exe_result_out = hi;
      OP_MFLO: bus.exe_result_out = lo;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: bus.exe_result_out = '0;
      default: bus.exe_result_out = a_r;
    endcase
  end

  assign bus.exe_allowin_out = allowin;
  assign bus.exe_valid_out   = valid_r && ready && !bus.flush_in;
  assign bus.exe_busy_out    = busy;
  assign bus.exe_hi_out      = hi;
  assign bus.exe_lo_out      = lo;
endmodule

// File: tb/tb_exe_muldiv_stage.sv
// tb/tb_exe_muldiv_stage.sv - directed and randomized checks of exe_muldiv_stage against an arithmetic model
module tb_exe_muldiv_stage;
  localparam int W  = 32;
  localparam int MC = 2;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  exe_muldiv_stage_if #(.DATA_W(W)) bus();

  exe_muldiv_stage #(.DATA_W(W), .MUL_CYCLES(MC), .DIV_EN(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected latency, result and the HI/LO visible during the final slot cycle
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res,
                       output logic [31:0] vhi, output logic [31:0] vlo);
    logic [63:0] p;
    int sa, sb;
    lat = 1;
    res = '0;
    vhi = m_hi;
    vlo = m_lo;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = p;
        lat = MC;
      end
      4'd2: begin
        p = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p;
        lat = MC;
      end
      4'd3: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
        lat = W + 1;
      end
      4'd4: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        lat = W + 1;
      end
      4'd5: res = m_hi;
      4'd6: res = m_lo;
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: res = a;
    endcase
    if (op >= 4'd1 && op <= 4'd4) begin
      vhi = m_hi;
      vlo = m_lo;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, n;
    logic [31:0] res, vhi, vlo;
    model(op, a, b, lat, res, vhi, vlo);
    check($sformatf("%s allowin", tag), bus.exe_allowin_out, 1);
    bus.id_valid_in = 1'b1;
    bus.id_op_in    = op;
    bus.id_src0_in  = a;
    bus.id_src1_in  = b;
    @(negedge clk);
    bus.id_valid_in = 1'b0;
    bus.id_op_in    = '0;
    n = 1;
    while (!bus.exe_valid_out && n < 200) begin
      check($sformatf("%s busy c%0d", tag, n), {bus.exe_busy_out, bus.exe_allowin_out}, 2'b10);
      @(negedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), n, lat);
    check($sformatf("%s result", tag), bus.exe_result_out, res);
    check($sformatf("%s hi", tag), bus.exe_hi_out, vhi);
    check($sformatf("%s lo", tag), bus.exe_lo_out, vlo);
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    bus.id_valid_in    = 1'b0;
    bus.mem_allowin_in = 1'b1;
    bus.flush_in       = 1'b0;
    bus.id_op_in       = '0;
    bus.id_src0_in     = '0;
    bus.id_src1_in     = '0;
    repeat (2) @(negedge clk);
    check("rst allowin", bus.exe_allowin_out, 1);
    check("rst valid", bus.exe_valid_out, 0);
    check("rst busy", bus.exe_busy_out, 0);
    check("rst result", bus.exe_result_out, 0);
    check("rst hilo", {bus.exe_hi_out, bus.exe_lo_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    check("mult hi const", bus.exe_hi_out, 32'hFFFF_FFFF);
    check("mult lo const", bus.exe_lo_out, 32'hFFFF_FFFA);
    run_op(4'd4, 32'd100, 32'd7, "divu");
    check("divu lo const", bus.exe_lo_out, 32'd14);
    check("divu hi const", bus.exe_hi_out, 32'd2);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div neg");
    check("div neg const", {bus.exe_hi_out, bus.exe_lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd3, 32'h1234_5678, 32'd0, "div zero");
    check("div zero const", {bus.exe_hi_out, bus.exe_lo_out}, 64'h1234_5678_FFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    check("div ovf const", {bus.exe_hi_out, bus.exe_lo_out}, 64'h0000_0000_8000_0000);

    // flush in the tenth cycle of a divide leaves HI/LO untouched
    run_op(4'd7, 32'h11, 32'd0, "mthi");
    run_op(4'd8, 32'h22, 32'd0, "mtlo");
    bus.id_valid_in = 1'b1;
    bus.id_op_in    = 4'd4;
    bus.id_src0_in  = 32'd5000;
    bus.id_src1_in  = 32'd3;
    @(negedge clk);
    bus.id_valid_in = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-flush busy", bus.exe_busy_out, 1);
    bus.flush_in       = 1'b1;
    bus.mem_allowin_in = 1'b0;
    check("flush gates valid", bus.exe_valid_out, 0);
    @(negedge clk);
    bus.flush_in = 1'b0;
    check("flush valid", bus.exe_valid_out, 0);
    check("flush busy", bus.exe_busy_out, 0);
    check("flush allowin", bus.exe_allowin_out, 1);
    check("flush hilo", {bus.exe_hi_out, bus.exe_lo_out}, 64'h0000_0011_0000_0022);
    bus.mem_allowin_in = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("flush hilo late", {bus.exe_hi_out, bus.exe_lo_out}, 64'h0000_0011_0000_0022);

    // MTLO then MFLO back-to-back, MFLO stalled by MEM
    run_op(4'd8, 32'h1234, 32'd0, "mtlo2");
    bus.id_valid_in = 1'b1;
    bus.id_op_in    = 4'd6;
    bus.id_src0_in  = 32'hDEAD;
    @(negedge clk);
    bus.id_valid_in    = 1'b0;
    bus.mem_allowin_in = 1'b0;
    check("mflo valid", bus.exe_valid_out, 1);
    check("mflo result", bus.exe_result_out, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d valid", i), bus.exe_valid_out, 1);
      check($sformatf("stall%0d result", i), bus.exe_result_out, 32'h1234);
      check($sformatf("stall%0d allowin", i), bus.exe_allowin_out, 0);
      check($sformatf("stall%0d lo", i), bus.exe_lo_out, 32'h1234);
    end
    bus.mem_allowin_in = 1'b1;
    @(negedge clk);
    check("stall drained", {bus.exe_valid_out, bus.exe_allowin_out}, 2'b01);

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      else b = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_op(op, a, b, $sformatf("rnd%0d op%0d", i, op));
    end

    // asynchronous reset with the clock stopped in the middle of a multiply
    run_op(4'd7, 32'h77, 32'd0, "mthi3");
    bus.id_valid_in = 1'b1;
    bus.id_op_in    = 4'd1;
    bus.id_src0_in  = 32'd9;
    bus.id_src1_in  = 32'd9;
    @(negedge clk);
    bus.id_valid_in = 1'b0;
    clk_en = 1'b0;
    check("mid-mult busy", bus.exe_busy_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst allowin", bus.exe_allowin_out, 1);
    check("arst valid", bus.exe_valid_out, 0);
    check("arst busy", bus.exe_busy_out, 0);
    check("arst result", bus.exe_result_out, 0);
    check("arst hilo", {bus.exe_hi_out, bus.exe_lo_out}, 0);
    #1 rst_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    #2 clk_en = 1'b1;
    @(negedge clk);
    run_op(4'd0, 32'hA5, 32'd0, "post-rst nop");
    check("post-rst nop const", bus.exe_result_out, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
